instr_prefetch_buffer: RTL and testbench
========================================

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, 8, byte-address width.
REQ-002 Parameter DATA_WIDTH, 32, instruction word width.
REQ-003 Parameter FIFO_DEPTH, 2, buffered instruction entries (power of two, >=2).
REQ-004 Parameter BOOT_ADDR, 0, first fetch address after reset.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 branch_i  input  1  redirect fetch; flush buffer.
REQ-008 branch_addr_i  input  ADDR_WIDTH  redirect target byte address.
REQ-009 ready_i  input  1  core accepts head instruction.
REQ-010 valid_o  output  1  head instruction available.
REQ-011 rdata_o  output  DATA_WIDTH  head instruction word.
REQ-012 addr_o  output  ADDR_WIDTH  byte address of head instruction.
REQ-013 instr_req_o  output  1  request to instruction memory.
REQ-014 instr_addr_o  output  ADDR_WIDTH  request byte address.
REQ-015 instr_gnt_i  input  1  memory accepted request (1-cycle pulse).
REQ-016 instr_rvalid_i  input  1  memory returns data (1-cycle pulse).
REQ-017 instr_rdata_i  input  DATA_WIDTH  returned word, valid with instr_rvalid_i.

Function
REQ-018 FSM states: IDLE (no request), REQ (instr_req_o=1, awaiting gnt), WAIT_RV (granted, awaiting rvalid); at most one request outstanding.
REQ-019 IDLE->REQ at the edge where fifo_count+outstanding < FIFO_DEPTH; instr_req_o is registered, equal to (state==REQ).
REQ-020 In REQ, instr_req_o and instr_addr_o shall remain stable until the cycle instr_gnt_i=1; then REQ->WAIT_RV.
REQ-021 WAIT_RV->REQ on instr_rvalid_i if space remains after the push, else ->IDLE.
REQ-022 fetch_addr increments by DATA_WIDTH/8 on each gnt, wrapping modulo 2^ADDR_WIDTH; low log2(DATA_WIDTH/8) bits always zero.
REQ-023 Non-discarded rvalid pushes {fetch word, its request address}; entry visible on valid_o the following cycle (1-cycle latency).
REQ-024 valid_o = buffer not empty; pop when valid_o && ready_i; push and pop in the same cycle leave count unchanged.
REQ-025 branch_i: buffer flushed and fetch_addr loaded with branch_addr_i (low bits cleared) at that edge; valid_o=0 next cycle; branch overrides a same-cycle pop and push.
REQ-026 branch_i while a request is in REQ or WAIT_RV (including same-cycle gnt): request completes unchanged, its rvalid data is discarded (discard flag), then fetching resumes at the branch target.
REQ-027 Second branch_i before the discarded response returns: target updated, only one response discarded.
REQ-028 instr_rvalid_i in IDLE or REQ with no outstanding request shall be ignored.

Reset
REQ-029 On rst=1 at an edge: state=IDLE, fetch_addr=BOOT_ADDR, buffer empty, discard flag clear.
REQ-030 During and after reset until first REQ: instr_req_o=0, instr_addr_o=BOOT_ADDR, valid_o=0, rdata_o=0, addr_o=0.
REQ-031 Reset mid-transaction abandons the outstanding request; a later stray rvalid is ignored per REQ-028.

Structure
REQ-032 Shared package fetch_pkg holds the FSM state enum (IDLE/REQ/WAIT_RV) and BYTES_PER_WORD constant.
REQ-033 Buffer is sub-module fetch_fifo (push, pop, flush, count, full/empty, DATA_WIDTH+ADDR_WIDTH payload).

Verification (memory model: 1-cycle gnt delay, 1-cycle rvalid delay; mem[0]=00D00113, mem[1]=00900093, mem[2]=401101B3)
REQ-034 Reset release, ready_i=1 -> requests at 0x00,0x04,0x08; core receives 00D00113@0x00, 00900093@0x04, 401101B3@0x08 in order.
REQ-035 ready_i=0 -> exactly FIFO_DEPTH=2 words buffered, instr_req_o stays 0; ready_i=1 -> fetching resumes at 0x08.
REQ-036 branch_i with branch_addr_i=0x80 while in WAIT_RV for 0x04 -> word from 0x04 never appears on valid_o; next valid_o shows addr_o=0x80, rdata_o=F81FF06F.
REQ-037 branch_addr_i=0x0B -> fetch issued at 0x08.
REQ-038 fetch_addr=0xFC -> next request at 0x00 (wrap).
REQ-039 rst asserted in WAIT_RV, rvalid arrives next cycle -> ignored, valid_o=0, new request at BOOT_ADDR.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM state type and word constants for the instruction prefetcher
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RV = 2'd2
    } fetch_state_e;

    localparam int INSTR_WIDTH    = 32;
    localparam int BYTES_PER_WORD = INSTR_WIDTH / 8;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small circular buffer of {instruction, address} entries with flush
module fetch_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the read side is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - single-outstanding instruction prefetcher with branch flush
module instr_prefetch_buffer import fetch_pkg::*; #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = BYTES_PER_WORD * 8,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_addr_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  instr_req_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [DATA_WIDTH-1:0] instr_rdata_i
);

    localparam int                    BPW        = DATA_WIDTH / 8;
    localparam int                    CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BPW);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPW - 1);
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]         DEPTH_C    = CW'(FIFO_DEPTH);

    fetch_state_e                     state;
    fetch_state_e                     state_next;
    logic [ADDR_WIDTH-1:0]            fetch_addr;
    logic [ADDR_WIDTH-1:0]            fetch_addr_next;
    logic [ADDR_WIDTH-1:0]            req_addr;
    logic                             discard;
    logic                             discard_next;
    logic                             push;
    logic                             pop;
    logic [CW-1:0]                    count;
    logic [CW-1:0]                    count_next;
    logic                             full;
    logic                             empty;
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] head;

    assign valid_o      = !empty;
    assign pop          = valid_o && ready_i;
    assign push         = (state == WAIT_RV) && instr_rvalid_i && !discard && !branch_i;
    assign instr_req_o  = (state == REQ);
    assign instr_addr_o = req_addr;
    assign rdata_o      = valid_o ? head[DATA_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH] : '0;
    assign addr_o       = valid_o ? head[ADDR_WIDTH-1:0] : '0;

    always_comb begin
        state_next      = state;
        fetch_addr_next = fetch_addr;
        discard_next    = discard;
        count_next      = count;

        if (branch_i)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CNT_ONE;
        else if (!push && pop)
            count_next = count - CNT_ONE;

        case (state)
            IDLE: begin
                if (!full) state_next = REQ;
            end
            REQ: begin
                // While a discard is pending, fetch_addr already holds the branch target.
                if (instr_gnt_i) begin
                    state_next = WAIT_RV;
                    if (!discard) fetch_addr_next = fetch_addr + ADDR_STEP;
                end
            end
            WAIT_RV: begin
                if (instr_rvalid_i) begin
                    discard_next = 1'b0;
                    state_next   = (count_next < DEPTH_C) ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A response still in flight belongs to the old path and must be dropped.
        if (branch_i) begin
            fetch_addr_next = branch_addr_i & ALIGN_MASK;
            if (state == REQ || (state == WAIT_RV && !instr_rvalid_i))
                discard_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_addr <= BOOT_ADDR & ALIGN_MASK;
            req_addr   <= BOOT_ADDR & ALIGN_MASK;
            discard    <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_addr <= fetch_addr_next;
            discard    <= discard_next;
            if (state_next == REQ && state != REQ)
                req_addr <= fetch_addr_next;
        end
    end

    fetch_fifo #(
        .WIDTH (DATA_WIDTH + ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_i),
        .wdata ({instr_rdata_i, req_addr}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb/tb_instr_prefetch_buffer.sv - scoreboard bench for instr_prefetch_buffer
module tb_instr_prefetch_buffer;

    logic        clk;
    logic        rst;
    logic        branch_i;
    logic [7:0]  branch_addr_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [7:0]  addr_o;
    logic        instr_req_o;
    logic [7:0]  instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;

    int n_pass  = 0;
    int n_total = 0;
    int req_cnt = 0;
    int out_cnt = 0;
    int rv_extra = 0;
    logic stray_rv = 1'b0;

    logic [7:0]  exp_req[$];
    logic [39:0] exp_out[$];

    instr_prefetch_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .rdata_o        (rdata_o),
        .addr_o         (addr_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        case (a)
            8'h00:   return 32'h00D0_0113;
            8'h04:   return 32'h0090_0093;
            8'h08:   return 32'h4011_01B3;
            8'h80:   return 32'hF81F_F06F;
            default: return 32'hC0DE_0000 | {24'h0, a};
        endcase
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Memory: gnt one cycle after req is seen, rvalid (1 + rv_extra) cycles after gnt.
    initial begin : memory
        logic       s_req, s_gnt, s_stray;
        logic [7:0] s_addr, rv_addr;
        int         rv_cd;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        rv_cd   = 0;
        rv_addr = '0;
        forever begin
            @(negedge clk);
            s_req   = instr_req_o;
            s_gnt   = instr_gnt_i;
            s_addr  = instr_addr_o;
            s_stray = stray_rv;
            @(posedge clk);
            #1;
            instr_gnt_i    = s_req && !s_gnt;
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
            if (s_gnt) begin
                rv_cd   = 1 + rv_extra;
                rv_addr = s_addr;
            end
            if (rv_cd > 0) begin
                rv_cd--;
                if (rv_cd == 0) begin
                    instr_rvalid_i = 1'b1;
                    instr_rdata_i  = mem_word(rv_addr);
                end
            end
            if (s_stray) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin : monitor
        logic [7:0]  e_req;
        logic [39:0] e_out;
        forever begin
            @(negedge clk);
            if (!rst && instr_req_o && instr_gnt_i) begin
                req_cnt++;
                if (exp_req.size() == 0)
                    check("req_unexpected", 40'(instr_addr_o), 40'hFF_FFFF_FFFF);
                else begin
                    e_req = exp_req.pop_front();
                    check("req_addr", 40'(instr_addr_o), 40'(e_req));
                end
            end
            if (!rst && valid_o && ready_i) begin
                out_cnt++;
                if (exp_out.size() == 0)
                    check("out_unexpected", {addr_o, rdata_o}, 40'hFF_FFFF_FFFF);
                else begin
                    e_out = exp_out.pop_front();
                    check("out_addr", 40'(addr_o), 40'(e_out[39:32]));
                    check("out_data", 40'(rdata_o), 40'(e_out[31:0]));
                end
            end
        end
    end

    task automatic push_run(input logic [7:0] start, input int n, input bit to_req, input bit to_out);
        logic [7:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            if (to_req) exp_req.push_back(a);
            if (to_out) exp_out.push_back({a, mem_word(a)});
            a = a + 8'd4;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        exp_req.delete();
        exp_out.delete();
        req_cnt = 0;
        out_cnt = 0;
        @(negedge clk);
        check("rst_req",   40'(instr_req_o),  40'h0);
        check("rst_iaddr", 40'(instr_addr_o), 40'h0);
        check("rst_valid", 40'(valid_o),      40'h0);
        check("rst_rdata", 40'(rdata_o),      40'h0);
        check("rst_addr",  40'(addr_o),       40'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 300 && out_cnt < n; i++) @(negedge clk);
        check("deliveries_reached", 40'(out_cnt >= n), 40'h1);
    endtask

    task automatic wait_grant(input logic [7:0] a);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = instr_req_o && instr_gnt_i && (instr_addr_o == a);
        end
        check("grant_seen", 40'(seen), 40'h1);
    endtask

    task automatic end_test();
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    initial begin : stimulus
        rst           = 1'b1;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        ready_i       = 1'b0;

        // In-order delivery from boot address
        do_reset();
        ready_i = 1'b1;
        exp_out.push_back({8'h00, 32'h00D0_0113});
        exp_out.push_back({8'h04, 32'h0090_0093});
        exp_out.push_back({8'h08, 32'h4011_01B3});
        push_run(8'h0C, 10, 1'b0, 1'b1);
        push_run(8'h00, 14, 1'b1, 1'b0);
        wait_out(4);
        end_test();

        // Back-pressure fills exactly two entries, stray rvalid in IDLE ignored
        do_reset();
        push_run(8'h00, 14, 1'b1, 1'b1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("full_req_cnt", 40'(req_cnt),     40'd2);
        check("full_req_low", 40'(instr_req_o), 40'h0);
        check("full_valid",   40'(valid_o),     40'h1);
        check("full_head",    {addr_o, rdata_o}, {8'h00, 32'h00D0_0113});
        @(posedge clk);
        #1;
        stray_rv = 1'b1;
        @(posedge clk);
        #1;
        stray_rv = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stray_req_cnt", 40'(req_cnt), 40'd2);
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        wait_out(5);
        end_test();

        // Branch to 0x80 while waiting on the 0x04 response
        do_reset();
        ready_i = 1'b1;
        exp_req.push_back(8'h00);
        exp_req.push_back(8'h04);
        push_run(8'h80, 12, 1'b1, 1'b0);
        exp_out.push_back({8'h00, 32'h00D0_0113});
        exp_out.push_back({8'h80, 32'hF81F_F06F});
        push_run(8'h84, 10, 1'b0, 1'b1);
        wait_grant(8'h04);
        @(posedge clk);
        #1;
        branch_i      = 1'b1;
        branch_addr_i = 8'h80;
        @(posedge clk);
        #1;
        branch_i = 1'b0;
        wait_out(4);
        end_test();

        // Branch on a granted request, then again before its delayed response; unaligned target
        rv_extra = 2;
        do_reset();
        ready_i = 1'b1;
        push_run(8'h00, 14, 1'b1, 1'b0);
        exp_out.push_back({8'h00, 32'h00D0_0113});
        exp_out.push_back({8'h08, 32'h4011_01B3});
        push_run(8'h0C, 10, 1'b0, 1'b1);
        wait_grant(8'h04);
        branch_i      = 1'b1;
        branch_addr_i = 8'h40;
        @(posedge clk);
        #1;
        branch_addr_i = 8'h0B;
        @(posedge clk);
        #1;
        branch_i = 1'b0;
        wait_out(4);
        end_test();
        rv_extra = 0;

        // Branch from IDLE to 0xF8 and wrap past 0xFC
        branch_i      = 1'b1;
        branch_addr_i = 8'hF8;
        do_reset();
        ready_i = 1'b1;
        exp_req.push_back(8'hF8);
        exp_req.push_back(8'hFC);
        push_run(8'h00, 12, 1'b1, 1'b0);
        exp_out.push_back({8'hF8, 32'hC0DE_00F8});
        exp_out.push_back({8'hFC, 32'hC0DE_00FC});
        exp_out.push_back({8'h00, 32'h00D0_0113});
        push_run(8'h04, 10, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        branch_i = 1'b0;
        wait_out(4);
        end_test();

        // Reset in WAIT_RV; response returning afterwards must be ignored
        rv_extra = 1;
        do_reset();
        ready_i = 1'b1;
        exp_req.push_back(8'h00);
        push_run(8'h00, 12, 1'b1, 1'b1);
        wait_grant(8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 40'(valid_o),      40'h0);
        check("midrst_req",   40'(instr_req_o),  40'h0);
        check("midrst_iaddr", 40'(instr_addr_o), 40'h0);
        @(negedge clk);
        check("midrst_valid2", 40'(valid_o),      40'h0);
        check("midrst_req2",   {instr_req_o, 31'h0, instr_addr_o}, {1'b1, 31'h0, 8'h00});
        wait_out(3);
        end_test();
        rv_extra = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
